mem_read_unit: RTL and testbench
================================

MEM_READ_UNIT -- requirements
Module: mem_read_unit

Interface
REQ-001 Parameter: WIDTH, 32, data and address width; only 32 is supported.
REQ-002 Parameter: TIMEOUT, 15, maximum REQ cycles without mem_ack before abort; legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  load request; sampled only in IDLE.
REQ-006 Port: addr  input  WIDTH  byte address of load.
REQ-007 Port: funct3  input  3  RISC-V load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 Port: busy  output  1  high in every state except IDLE.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: rdata  output  WIDTH  aligned, extended load result.
REQ-011 Port: err  output  1  misaligned/illegal request; valid while done=1.
REQ-012 Port: timeout  output  1  memory did not acknowledge; valid while done=1.
REQ-013 Port: mem_req  output  1  memory read request, registered.
REQ-014 Port: mem_addr  output  WIDTH  word address {addr[31:2],2'b00}, registered.
REQ-015 Port: mem_ack  input  1  memory acknowledge; mem_rdata valid in same cycle.
REQ-016 Port: mem_rdata  input  WIDTH  memory read word.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DONE; all outputs registered.
REQ-018 IDLE, start=1, legal funct3, aligned addr: latch addr[1:0] and funct3; mem_addr <= word address; mem_req <= 1; cycle counter <= 0; next REQ.
REQ-019 Alignment: LH/LHU need addr[0]=0; LW needs addr[1:0]=00; LB/LBU always aligned.
REQ-020 IDLE, start=1, illegal funct3 (011,110,111) or misaligned: next DONE with err=1, rdata=0, mem_req never asserted.
REQ-021 REQ: mem_req and mem_addr SHALL stay constant until mem_ack=1 is sampled or timeout fires.
REQ-022 REQ, mem_ack=1: capture extracted data into rdata, mem_req <= 0, next DONE, err=0, timeout=0.
REQ-023 REQ, mem_ack=0: counter increments; when counter reaches TIMEOUT-1 with no ack, mem_req <= 0, rdata <= 0, timeout <= 1, next DONE.
REQ-024 mem_ack and the timeout condition in the same cycle: ack wins, data captured, timeout=0.
REQ-025 DONE: done=1 for exactly one cycle; next IDLE unconditionally.
REQ-026 rdata, err and timeout SHALL hold their values in IDLE until the next accepted start.
REQ-027 start while busy=1 SHALL be ignored (no queueing); mem_ack outside REQ SHALL be ignored.
REQ-028 Extraction: lane=addr[1:0]; byte = mem_rdata[8*lane+7:8*lane]; half = mem_rdata[16*addr[1]+15:16*addr[1]].
REQ-029 LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes mem_rdata unchanged.
REQ-030 Latency: start sampled at edge N, ack present in first REQ cycle -> done high in cycle after edge N+1; each ack-wait cycle adds one.
REQ-031 Back-to-back: start asserted in the IDLE cycle following DONE SHALL be accepted.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, err=0, timeout=0, mem_req=0, mem_addr=0, rdata=0, counter=0, independent of clk.
REQ-033 Reset asserted during REQ SHALL drop mem_req without waiting for mem_ack; an ack arriving after reset release SHALL be ignored.
REQ-034 First start SHALL be accepted on the first rising edge with reset_n=1.

Verification
REQ-035 LB addr=0x103, mem_rdata=0x80FF1234, ack in first REQ cycle -> mem_addr=0x100, rdata=0xFFFFFF80, done after 2 cycles, err=0.
REQ-036 LHU addr=0x202, mem_rdata=0xBEEF0000, ack after 3 wait cycles -> rdata=0x0000BEEF, mem_req held 4 cycles with mem_addr=0x200 stable.
REQ-037 LW addr=0x6, or funct3=011 -> done next cycle, err=1, rdata=0, mem_req never high.
REQ-038 TIMEOUT=4, mem_ack held 0 -> mem_req high exactly 4 cycles, then done=1, timeout=1, rdata=0; ack coincident with 4th cycle -> data captured, timeout=0.
REQ-039 reset_n pulsed low mid-REQ, then ack -> mem_req low asynchronously, no done pulse, all outputs zero, next start serviced normally.
REQ-040 Two LW requests, start held high continuously -> second accepted only in the IDLE cycle after done, both results correct, start ignored while busy.

Source files
------------

// File: rtl/mem_read_if.sv
// Load-unit bus: CPU-side start/result signals plus the memory read channel.
interface mem_read_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] addr;
  logic [2:0]       funct3;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rdata;
  logic             err;
  logic             timeout;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  start, addr, funct3, mem_ack, mem_rdata,
    output busy, done, rdata, err, timeout, mem_req, mem_addr
  );

  modport master (
    output start, addr, funct3, mem_ack, mem_rdata,
    input  busy, done, rdata, err, timeout, mem_req, mem_addr
  );
endinterface

// File: rtl/mem_read_unit.sv
// RISC-V load unit: one word read, lane extract and sign/zero extend; done 2 cycles after start with an immediate ack.
// Holds mem_req until mem_ack or TIMEOUT REQ cycles; start is ignored while busy, no queueing.
module mem_read_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  mem_read_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       lane;
  logic [2:0]       f3;
  logic [7:0]       cnt;
  logic             legal;
  logic             aligned;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] ext;

  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    case (bus.funct3)
      F_LB, F_LBU: begin legal = 1'b1; aligned = 1'b1; end
      F_LH, F_LHU: begin legal = 1'b1; aligned = ~bus.addr[0]; end
      F_LW:        begin legal = 1'b1; aligned = (bus.addr[1:0] == 2'b00); end
      default:     begin legal = 1'b0; aligned = 1'b0; end
    endcase
  end

  // Extraction uses the lane/type latched at accept, not the live inputs.
  always_comb begin
    byte_sel = bus.mem_rdata[{lane, 3'b000} +: 8];
    half_sel = bus.mem_rdata[{lane[1], 4'b0000} +: 16];
    case (f3)
      F_LB:    ext = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      F_LBU:   ext = {{(WIDTH-8){1'b0}}, byte_sel};
      F_LH:    ext = {{(WIDTH-16){half_sel[15]}}, half_sel};
      F_LHU:   ext = {{(WIDTH-16){1'b0}}, half_sel};
      default: ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      lane         <= 2'b00;
      f3           <= 3'b000;
      cnt          <= 8'd0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rdata    <= '0;
      bus.err      <= 1'b0;
      bus.timeout  <= 1'b0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.busy    <= 1'b1;
            bus.rdata   <= '0;
            bus.timeout <= 1'b0;
            if (legal && aligned) begin
              lane         <= bus.addr[1:0];
              f3           <= bus.funct3;
              bus.mem_addr <= {bus.addr[WIDTH-1:2], 2'b00};
              bus.mem_req  <= 1'b1;
              bus.err      <= 1'b0;
              cnt          <= 8'd0;
              state        <= S_REQ;
            end else begin
              bus.err  <= 1'b1;
              bus.done <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_REQ: begin
          // An ack in the final wait cycle beats the timeout.
          if (bus.mem_ack) begin
            bus.rdata   <= ext;
            bus.mem_req <= 1'b0;
            bus.done    <= 1'b1;
            state       <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            bus.rdata   <= '0;
            bus.timeout <= 1'b1;
            bus.mem_req <= 1'b0;
            bus.done    <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.done    <= 1'b0;
          bus.busy    <= 1'b0;
          bus.mem_req <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_read_unit.sv
// Bench for mem_read_unit: directed vector table, random loads against a reference model, and multi-cycle corner sequences.
module tb_mem_read_unit;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  mem_read_if #(.WIDTH(32)) bus();

  mem_read_unit #(.WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] word;
    int          dly;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          lat;
    int          reqc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic [2:0] f, input logic [31:0] w, input int d,
                     input logic [31:0] r, input logic e, input logic t, input int l, input int q);
    vec_t v;
    v.addr = a; v.f3 = f; v.word = w; v.dly = d;
    v.rdata = r; v.err = e; v.to = t; v.lat = l; v.reqc = q;
    vecs.push_back(v);
  endtask

  // Reference: access size from funct3, alignment by modulo, extract by shifting the word.
  function automatic vec_t model(input logic [31:0] a, input logic [2:0] f, input logic [31:0] w, input int d);
    vec_t v;
    int unsigned size;
    logic [31:0] sh;
    v.addr = a; v.f3 = f; v.word = w; v.dly = d;
    v.rdata = 32'd0; v.err = 1'b0; v.to = 1'b0;
    case (f)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0 || (a % size) != 0) begin
      v.err = 1'b1; v.lat = 1; v.reqc = 0;
    end else if (d >= TMO) begin
      v.to = 1'b1; v.lat = TMO + 1; v.reqc = TMO;
    end else begin
      v.lat = d + 2; v.reqc = d + 1;
      sh = w >> (8 * (a % 4));
      if (size == 1) begin
        v.rdata = sh & 32'hFF;
        if (f == 3'd0 && v.rdata[7]) v.rdata = v.rdata + 32'hFFFF_FF00;
      end else if (size == 2) begin
        v.rdata = sh & 32'hFFFF;
        if (f == 3'd1 && v.rdata[15]) v.rdata = v.rdata + 32'hFFFF_0000;
      end else begin
        v.rdata = w;
      end
    end
    return v;
  endfunction

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  // Called at a negedge; issues one start, plays memory with an ack after dly wait cycles.
  task automatic run_op(input logic [31:0] a, input logic [2:0] f, input logic [31:0] w, input int dly,
                        input string nm, output logic [31:0] rd, output logic e, output logic t,
                        output int lat, output int reqc);
    int cyc = 0;
    int reqj = 0;
    bit got = 0;
    bit addr_ok = 1;
    rd = 32'd0; e = 1'b0; t = 1'b0; lat = 0; reqc = 0;
    bus.start = 1'b1; bus.addr = a; bus.funct3 = f;
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, " busy"}, 32'(bus.busy), 32'd1);
    while (!got && cyc < 40) begin
      cyc++;
      bus.mem_ack = 1'b0;
      if (bus.done) begin
        got = 1; rd = bus.rdata; e = bus.err; t = bus.timeout; lat = cyc;
      end else begin
        if (bus.mem_req) begin
          reqc++;
          if (bus.mem_addr !== {a[31:2], 2'b00}) addr_ok = 0;
          bus.mem_ack   = (reqj == dly);
          bus.mem_rdata = (reqj == dly) ? w : $urandom;
          reqj++;
        end
        @(negedge clk);
      end
    end
    bus.mem_ack = 1'b0;
    chk({nm, " done seen"}, 32'(got), 32'd1);
    chk({nm, " mem_addr stable"}, 32'(addr_ok), 32'd1);
    @(negedge clk);
    chk({nm, " done one cycle"}, {30'd0, bus.done, bus.busy}, 32'd0);
    chk({nm, " rdata held"}, bus.rdata, rd);
  endtask

  task automatic compare(input string nm, input vec_t exp, input logic [31:0] rd, input logic e,
                         input logic t, input int lat, input int reqc);
    chk({nm, " rdata"}, rd, exp.rdata);
    chk({nm, " err"}, 32'(e), 32'(exp.err));
    chk({nm, " timeout"}, 32'(t), 32'(exp.to));
    chk({nm, " latency"}, lat, exp.lat);
    chk({nm, " req cycles"}, reqc, exp.reqc);
  endtask

  initial begin
    logic [31:0] rd;
    logic e, t;
    int lat, reqc, seen;
    int rc[2];
    int dc[2];
    logic [31:0] dv[2];
    int nr, nd;
    logic prev_req;

    reset_n = 1'b0;
    bus.start = 1'b0; bus.addr = '0; bus.funct3 = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #2;
    chk("reset busy/done/err/to/req", {27'd0, bus.busy, bus.done, bus.err, bus.timeout, bus.mem_req}, 32'd0);
    chk("reset rdata", bus.rdata, 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    add(32'h103, 3'd0, 32'h80FF_1234, 0,  32'hFFFF_FF80, 0, 0, 2, 1);
    add(32'h202, 3'd5, 32'hBEEF_0000, 3,  32'h0000_BEEF, 0, 0, 5, 4);
    add(32'h006, 3'd2, 32'h1111_1111, 0,  32'h0,         1, 0, 1, 0);
    add(32'h010, 3'd3, 32'h2222_2222, 0,  32'h0,         1, 0, 1, 0);
    add(32'h040, 3'd2, 32'h3333_3333, 99, 32'h0,         0, 1, 5, 4);
    add(32'h044, 3'd2, 32'hDEAD_BEEF, 3,  32'hDEAD_BEEF, 0, 0, 5, 4);
    add(32'h002, 3'd1, 32'h8001_7FFF, 1,  32'hFFFF_8001, 0, 0, 3, 2);
    add(32'h101, 3'd4, 32'h0000_80AB, 0,  32'h0000_0080, 0, 0, 2, 1);
    add(32'h001, 3'd1, 32'h4444_4444, 0,  32'h0,         1, 0, 1, 0);
    add(32'h020, 3'd6, 32'h5555_5555, 0,  32'h0,         1, 0, 1, 0);
    add(32'h024, 3'd7, 32'h6666_6666, 0,  32'h0,         1, 0, 1, 0);
    add(32'h000, 3'd5, 32'h1234_F00D, 2,  32'h0000_F00D, 0, 0, 4, 3);
    add(32'h000, 3'd1, 32'h0000_8000, 0,  32'hFFFF_8000, 0, 0, 2, 1);
    add(32'h007, 3'd0, 32'h7F00_0000, 1,  32'h0000_007F, 0, 0, 3, 2);
    add(32'h003, 3'd5, 32'h7777_7777, 0,  32'h0,         1, 0, 1, 0);

    // First vector starts on the first rising edge after reset release.
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].addr, vecs[i].f3, vecs[i].word, vecs[i].dly, $sformatf("vec%0d", i), rd, e, t, lat, reqc);
      compare($sformatf("vec%0d", i), vecs[i], rd, e, t, lat, reqc);
    end

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a, w;
      logic [2:0] f;
      int d;
      vec_t m;
      a = $urandom; w = $urandom; f = 3'($urandom_range(0, 7)); d = $urandom_range(0, 5);
      if (i % 2 == 0) a[1:0] = 2'b00;
      m = model(a, f, w, d);
      run_op(a, f, w, d, $sformatf("rnd%0d", i), rd, e, t, lat, reqc);
      compare($sformatf("rnd%0d", i), m, rd, e, t, lat, reqc);
    end

    // Start held high across two LW loads: second accepted only in the IDLE cycle after done.
    rc = '{-1, -1}; dc = '{-1, -1}; dv = '{32'd0, 32'd0}; nr = 0; nd = 0; prev_req = 1'b0;
    bus.start = 1'b1; bus.addr = 32'h300; bus.funct3 = 3'd2;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.mem_ack = bus.mem_req;
      bus.mem_rdata = mem_of(bus.mem_addr);
      if (bus.mem_req && !prev_req && nr < 2) begin rc[nr] = c; nr++; bus.addr = 32'h304; end
      prev_req = bus.mem_req;
      if (bus.done && nd < 2) begin
        dc[nd] = c; dv[nd] = bus.rdata; nd++;
        if (nd == 2) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0; bus.mem_ack = 1'b0;
    chk("b2b req count", nr, 2);
    chk("b2b first req cycle", rc[0], 1);
    chk("b2b second req cycle", rc[1], 4);
    chk("b2b first done cycle", dc[0], 2);
    chk("b2b second done cycle", dc[1], 5);
    chk("b2b first rdata", dv[0], mem_of(32'h300));
    chk("b2b second rdata", dv[1], mem_of(32'h304));

    // mem_ack in IDLE changes nothing.
    rd = bus.rdata; seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
      if (bus.busy || bus.done || bus.mem_req || bus.rdata !== rd) seen++;
    end
    @(negedge clk);
    if (bus.busy || bus.done || bus.mem_req || bus.rdata !== rd) seen++;
    bus.mem_ack = 1'b0;
    chk("idle ack ignored", seen, 0);

    // Reset mid-REQ: mem_req drops at once, a late ack is ignored, next load is normal.
    @(negedge clk);
    bus.start = 1'b1; bus.addr = 32'h500; bus.funct3 = 3'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("pre-reset mem_req", 32'(bus.mem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset flags", {27'd0, bus.busy, bus.done, bus.err, bus.timeout, bus.mem_req}, 32'd0);
    chk("async reset rdata", bus.rdata, 32'd0);
    chk("async reset mem_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
      @(negedge clk);
      if (bus.done || bus.busy || bus.mem_req) seen++;
    end
    bus.mem_ack = 1'b0;
    chk("late ack ignored", seen, 0);
    run_op(32'h502, 3'd0, 32'h00C3_0000, 1, "post-reset", rd, e, t, lat, reqc);
    compare("post-reset", model(32'h502, 3'd0, 32'h00C3_0000, 1), rd, e, t, lat, reqc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
